// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control: FSM encoding, forward
// selects, stall bit positions and the NOP opcode.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_DWAIT = 2'd2,
    ST_FAULT = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;

  localparam logic [4:0] STALL_NONE  = 5'b00000;
  localparam logic [4:0] STALL_FRONT = (5'b1 << STALL_PC) | (5'b1 << STALL_IFID);
  localparam logic [4:0] STALL_ALL   = STALL_FRONT | (5'b1 << STALL_IDEX) |
                                       (5'b1 << STALL_EXMEM) | (5'b1 << STALL_MEMWB);

  localparam logic [5:0] NOP_OPCODE = 6'd63;

  // A load result in MEM is not yet available, so only a non-load MEM hit forwards.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic mem_is_load,
                                         input logic wb_hit);
    if (mem_hit && !mem_is_load) return FWD_MEM;
    if (wb_hit) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID-stage source register against the EX, MEM and WB producers.
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wen,
  output logic              ex_hit,
  output logic              mem_hit,
  output logic              wb_hit
);

  // r0 is hardwired to zero and never creates a dependency.
  assign ex_hit  = use_src && ex_wen  && (ex_rd  != '0) && (ex_rd  == src);
  assign mem_hit = use_src && mem_wen && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = use_src && wb_wen  && (wb_rd  != '0) && (wb_rd  == src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS core: stalls, bubbles, flushes, forwarding
// and memory-miss tracking. Forwarding is enabled by defining PIPE_FWD_EN.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch_taken,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wen,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_wen,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_wen,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic [4:0]        stall,
  output logic              nop,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_fault,
  output logic [31:0]       wait_cycles,
  output ctrl_state_e       state_dbg
);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_fault_q, mem_fault_d;
  logic [31:0]       wait_cycles_q, wait_cycles_d;

  logic ex_hit_a, mem_hit_a, wb_hit_a;
  logic ex_hit_b, mem_hit_b, wb_hit_b;
  logic dh, dmiss, d_block, i_block, redirect;

  hazard_match #(.REG_AW(REG_AW)) u_match_rs (
    .src(id_rs), .use_src(id_use_rs),
    .ex_rd(ex_rd), .ex_wen(ex_reg_wen),
    .mem_rd(mem_rd), .mem_wen(mem_reg_wen),
    .wb_rd(wb_rd), .wb_wen(wb_reg_wen),
    .ex_hit(ex_hit_a), .mem_hit(mem_hit_a), .wb_hit(wb_hit_a)
  );

  hazard_match #(.REG_AW(REG_AW)) u_match_rt (
    .src(id_rt), .use_src(id_use_rt),
    .ex_rd(ex_rd), .ex_wen(ex_reg_wen),
    .mem_rd(mem_rd), .mem_wen(mem_reg_wen),
    .wb_rd(wb_rd), .wb_wen(wb_reg_wen),
    .ex_hit(ex_hit_b), .mem_hit(mem_hit_b), .wb_hit(wb_hit_b)
  );

`ifdef PIPE_FWD_EN
  assign dh = ex_hit_a || ex_hit_b || (mem_mem_read && (mem_hit_a || mem_hit_b));
`else
  // Without bypass paths every in-flight producer must retire before ID reads.
  assign dh = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b || wb_hit_a || wb_hit_b;
`endif

  assign dmiss    = !dmem_ready && (mem_mem_read || mem_mem_write);
  assign d_block  = (state_q == ST_DWAIT) ? !dmem_ready : dmiss;
  assign i_block  = !imem_ready;
  assign redirect = (id_jump || id_branch_taken) && !dh;

  always_comb begin
    stall      = STALL_NONE;
    nop        = 1'b0;
    flush_ifid = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
`ifdef PIPE_FWD_EN
    fwd_a = fwd_sel(mem_hit_a, mem_mem_read, wb_hit_a);
    fwd_b = fwd_sel(mem_hit_b, mem_mem_read, wb_hit_b);
`endif
    if (Rst) begin
      stall      = STALL_ALL;
      nop        = 1'b1;
      flush_ifid = 1'b1;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
    end else if (state_q == ST_FAULT) begin
      stall = STALL_ALL;
    end else if (d_block) begin
      stall = STALL_ALL;
    end else if (i_block) begin
      // A redirect still takes its target; the miss is tracked for the new fetch.
      if (redirect) begin
        flush_ifid = 1'b1;
      end else begin
        stall = STALL_FRONT;
        nop   = 1'b1;
      end
    end else if (dh) begin
      stall = STALL_FRONT;
      nop   = 1'b1;
    end else if (redirect) begin
      flush_ifid = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (dmiss) begin
          state_d = ST_DWAIT;
          cnt_d   = CNT_W'(1);
        end else if (!imem_ready) begin
          state_d = ST_IWAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_DWAIT: begin
        if (dmem_ready) begin
          state_d = imem_ready ? ST_RUN : ST_IWAIT;
          cnt_d   = imem_ready ? '0 : CNT_W'(1);
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IWAIT: begin
        if (imem_ready) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    mem_fault_d   = mem_fault_q || (state_d == ST_FAULT);
    wait_cycles_d = wait_cycles_q;
    if ((stall != STALL_NONE) && (wait_cycles_q != 32'hFFFF_FFFF))
      wait_cycles_d = wait_cycles_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      mem_fault_q   <= 1'b0;
      wait_cycles_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_fault_q   <= mem_fault_d;
      wait_cycles_q <= wait_cycles_d;
    end
  end

  assign mem_fault   = mem_fault_q;
  assign wait_cycles = wait_cycles_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, forwarding, memory waits and timeout.
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs, id_use_rt, id_branch_taken, id_jump;
  logic        ex_reg_wen, mem_reg_wen, mem_mem_read, mem_mem_write, wb_reg_wen;
  logic        imem_ready, dmem_ready;
  logic [4:0]  stall;
  logic        nop, flush_ifid, mem_fault;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] wait_cycles;
  ctrl_state_e state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stall(stall), .nop(nop), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fault(mem_fault),
    .wait_cycles(wait_cycles), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic next_step();
    @(negedge Clk);
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch_taken = 1'b0; id_jump = 1'b0;
    ex_rd = 5'd0; ex_reg_wen = 1'b0;
    mem_rd = 5'd0; mem_reg_wen = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    wb_rd = 5'd0; wb_reg_wen = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] e_stall, input logic e_nop,
                           input logic e_flush);
    check({tag, "_stall"}, 32'(stall), 32'(e_stall));
    check({tag, "_nop"}, 32'(nop), 32'(e_nop));
    check({tag, "_flush"}, 32'(flush_ifid), 32'(e_flush));
  endtask

  initial begin
    idle();
    // Reset overrides a live WB match on the forward selects.
    id_rs = 5'd3; id_use_rs = 1'b1; wb_rd = 5'd3; wb_reg_wen = 1'b1;
    next_step(); #1;
    check_ctl("rst", 5'b11111, 1'b1, 1'b1);
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_wait", wait_cycles, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_RUN));

    next_step(); Rst = 1'b0; idle(); #1;
    check_ctl("idle", 5'b00000, 1'b0, 1'b0);

    // ALU producer to r8 walking EX -> MEM -> WB while ID reads r8 as rs.
    next_step(); idle(); id_rs = 5'd8; id_use_rs = 1'b1; ex_rd = 5'd8; ex_reg_wen = 1'b1; #1;
    check_ctl("alu_ex", 5'b00011, 1'b1, 1'b0);
    next_step(); idle(); id_rs = 5'd8; id_use_rs = 1'b1; mem_rd = 5'd8; mem_reg_wen = 1'b1; #1;
    check("alu_mem_stall", 32'(stall), FWD ? 32'h00 : 32'h03);
    check("alu_mem_fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
    next_step(); idle(); id_rs = 5'd8; id_use_rs = 1'b1; wb_rd = 5'd8; wb_reg_wen = 1'b1; #1;
    check("alu_wb_stall", 32'(stall), FWD ? 32'h00 : 32'h03);
    check("alu_wb_fwd_a", 32'(fwd_a), FWD ? 32'd2 : 32'd0);

    // Load to r9 walking EX -> MEM -> WB while ID reads r9 as rt.
    next_step(); idle(); id_rt = 5'd9; id_use_rt = 1'b1; ex_rd = 5'd9; ex_reg_wen = 1'b1; #1;
    check_ctl("ld_ex", 5'b00011, 1'b1, 1'b0);
    next_step(); idle(); id_rt = 5'd9; id_use_rt = 1'b1;
    mem_rd = 5'd9; mem_reg_wen = 1'b1; mem_mem_read = 1'b1; #1;
    check_ctl("ld_mem", 5'b00011, 1'b1, 1'b0);
    check("ld_mem_fwd_b", 32'(fwd_b), 32'd0);
    next_step(); idle(); id_rt = 5'd9; id_use_rt = 1'b1; wb_rd = 5'd9; wb_reg_wen = 1'b1; #1;
    check("ld_wb_stall", 32'(stall), FWD ? 32'h00 : 32'h03);
    check("ld_wb_fwd_b", 32'(fwd_b), FWD ? 32'd2 : 32'd0);

    // MEM and WB both write r4: MEM wins.
    next_step(); idle(); id_rs = 5'd4; id_use_rs = 1'b1;
    mem_rd = 5'd4; mem_reg_wen = 1'b1; wb_rd = 5'd4; wb_reg_wen = 1'b1; #1;
    check("prio_fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);
    check("prio_fwd_b", 32'(fwd_b), 32'd0);

    // r0 producers everywhere never match.
    next_step(); idle(); id_use_rs = 1'b1; id_use_rt = 1'b1;
    ex_reg_wen = 1'b1; mem_reg_wen = 1'b1; wb_reg_wen = 1'b1; #1;
    check_ctl("r0", 5'b00000, 1'b0, 1'b0);
    check("r0_fwd_a", 32'(fwd_a), 32'd0);
    check("r0_fwd_b", 32'(fwd_b), 32'd0);

    // Matching register but source not used.
    next_step(); idle(); id_rs = 5'd5; ex_rd = 5'd5; ex_reg_wen = 1'b1; #1;
    check_ctl("unused_src", 5'b00000, 1'b0, 1'b0);

    // Jump, then plain cycle, then taken branch blocked by a hazard.
    next_step(); idle(); id_jump = 1'b1; #1;
    check_ctl("jump", 5'b00000, 1'b0, 1'b1);
    next_step(); idle(); #1;
    check_ctl("after_jump", 5'b00000, 1'b0, 1'b0);
    next_step(); idle(); id_branch_taken = 1'b1; id_rs = 5'd7; id_use_rs = 1'b1;
    ex_rd = 5'd7; ex_reg_wen = 1'b1; #1;
    check_ctl("br_dh", 5'b00011, 1'b1, 1'b0);

    // Fresh counters for the dmem miss.
    next_step(); idle(); Rst = 1'b1; #1;
    check("rst2_wait", wait_cycles, 32'd0);
    next_step(); Rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      next_step(); idle(); mem_rd = 5'd12; mem_reg_wen = 1'b1; mem_mem_read = 1'b1;
      dmem_ready = 1'b0; #1;
      check("dmiss_stall", 32'(stall), 32'h1F);
      check("dmiss_state", 32'(state_dbg), (i == 0) ? 32'(ST_RUN) : 32'(ST_DWAIT));
    end
    next_step(); idle(); mem_rd = 5'd12; mem_reg_wen = 1'b1; mem_mem_read = 1'b1; #1;
    check_ctl("dmiss_release", 5'b00000, 1'b0, 1'b0);
    next_step(); idle(); #1;
    check("dmiss_wait", wait_cycles, 32'd4);
    check("dmiss_run", 32'(state_dbg), 32'(ST_RUN));

    // Simultaneous misses: DWAIT first, then straight into IWAIT.
    next_step(); idle(); mem_mem_write = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0; #1;
    check_ctl("both_miss", 5'b11111, 1'b0, 1'b0);
    next_step(); idle(); imem_ready = 1'b0; #1;
    check("both_dwait", 32'(state_dbg), 32'(ST_DWAIT));
    check_ctl("both_dexit", 5'b00011, 1'b1, 1'b0);
    next_step(); idle(); #1;
    check("both_iwait", 32'(state_dbg), 32'(ST_IWAIT));
    check_ctl("both_irel", 5'b00000, 1'b0, 1'b0);
    next_step(); idle(); #1;
    check("both_run", 32'(state_dbg), 32'(ST_RUN));

    // Imem miss for 16 cycles, the first coinciding with a jump.
    next_step(); idle(); imem_ready = 1'b0; id_jump = 1'b1; #1;
    check_ctl("imiss_jump", 5'b00000, 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) begin
      next_step(); idle(); imem_ready = 1'b0; #1;
      check("imiss_stall", 32'(stall), 32'h03);
      check("imiss_state", 32'(state_dbg), 32'(ST_IWAIT));
    end
    check("imiss_nofault_yet", 32'(mem_fault), 32'd0);
    next_step(); idle(); #1;
    check("fault_state", 32'(state_dbg), 32'(ST_FAULT));
    check("fault_flag", 32'(mem_fault), 32'd1);
    check_ctl("fault", 5'b11111, 1'b0, 1'b0);
    next_step(); idle(); id_jump = 1'b1; #1;
    check("fault_sticky", 32'(mem_fault), 32'd1);
    check_ctl("fault_jump", 5'b11111, 1'b0, 1'b0);

    next_step(); idle(); Rst = 1'b1; #1;
    check("rst3_fault", 32'(mem_fault), 32'd0);
    check("rst3_state", 32'(state_dbg), 32'(ST_RUN));
    check("rst3_wait", wait_cycles, 32'd0);
    check_ctl("rst3", 5'b11111, 1'b1, 1'b1);
    next_step(); Rst = 1'b0; #1;
    check_ctl("post_rst", 5'b00000, 1'b0, 1'b0);
    next_step(); #1;
    check("post_rst_state", 32'(state_dbg), 32'(ST_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
